// File: rtl/branch_unit.sv
// Branch resolution unit with a one-entry result register using a valid/ready handshake.
// Define BRANCH_UNIT_STATS_EN to add the saturating taken_cnt and total_cnt outputs.
module branch_unit #(
  parameter int N          = 16,
  parameter int INSN_BYTES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   br_op,
  input  logic         eq,
  input  logic         gt,
  input  logic         lt,
  input  logic [N-1:0] pc_in,
  input  logic [N-1:0] offset,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] target,
  output logic [N-1:0] next_pc,
  output logic         flags_err
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [15:0]  taken_cnt,
  output logic [15:0]  total_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic         accept;
  logic         taken_q, taken_d;
  logic         ferr_q, ferr_d;
  logic [N-1:0] target_q, target_d;
  logic [N-1:0] next_pc_q, next_pc_d;
  logic         cond_op, raw_taken;

  assign in_ready = !rst && !flush && ((state_q == EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                             state_d = EMPTY;
    else if (accept)                       state_d = FULL;
    else if (state_q == FULL && out_ready) state_d = EMPTY;
  end

  always_comb begin
    out_valid = (state_q == FULL);
    taken     = taken_q;
    flags_err = ferr_q;
    target    = target_q;
    next_pc   = next_pc_q;
  end

  // Codes 000..011 are the conditional ops; 100 is JAL, the rest are NOP.
  always_comb begin
    cond_op   = !br_op[2];
    raw_taken = 1'b0;
    unique case (br_op)
      3'b000:  raw_taken = eq;
      3'b001:  raw_taken = !eq;
      3'b010:  raw_taken = lt;
      3'b011:  raw_taken = eq || gt;
      3'b100:  raw_taken = 1'b1;
      default: raw_taken = 1'b0;
    endcase
    ferr_d    = cond_op && !$onehot({eq, gt, lt});
    taken_d   = raw_taken && !ferr_d;
    target_d  = pc_in + offset;
    next_pc_d = taken_d ? target_d : (pc_in + N'(INSN_BYTES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q   <= 1'b0;
      ferr_q    <= 1'b0;
      target_q  <= '0;
      next_pc_q <= '0;
    end else if (accept) begin
      taken_q   <= taken_d;
      ferr_q    <= ferr_d;
      target_q  <= target_d;
      next_pc_q <= next_pc_d;
    end
  end

`ifdef BRANCH_UNIT_STATS_EN
  logic [15:0] taken_cnt_q, total_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= '0;
      total_cnt_q <= '0;
    end else if (accept) begin
      if (total_cnt_q != 16'hFFFF)            total_cnt_q <= total_cnt_q + 16'd1;
      if (taken_d && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign total_cnt = total_cnt_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed scenarios followed by random traffic
// checked against an arithmetic reference model.
module tb_branch_unit;
  localparam int N    = 16;
  localparam int INSN = 2;
  localparam int MOD  = 1 << N;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, eq, gt, lt, flush;
  logic         out_valid, out_ready, taken, flags_err;
  logic [2:0]   br_op;
  logic [N-1:0] pc_in, offset, target, next_pc;
`ifdef BRANCH_UNIT_STATS_EN
  logic [15:0]  taken_cnt, total_cnt;
  int           m_taken = 0, m_total = 0;
`endif

  branch_unit #(.N(N), .INSN_BYTES(INSN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .eq(eq), .gt(gt), .lt(lt), .pc_in(pc_in), .offset(offset),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .next_pc(next_pc), .flags_err(flags_err)
`ifdef BRANCH_UNIT_STATS_EN
    , .taken_cnt(taken_cnt), .total_cnt(total_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         taken;
    logic         ferr;
    logic [N-1:0] target;
    logic [N-1:0] next_pc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rst_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Resolution written from the rule table with plain integer arithmetic.
  function automatic exp_t model(int op, bit e, bit g, bit l, int pc, int off);
    exp_t r;
    int   soff    = (off >= MOD / 2) ? off - MOD : off;
    int   nflags  = int'(e) + int'(g) + int'(l);
    bit   is_cond = (op <= 3);
    bit   t;
    case (op)
      0:       t = e;
      1:       t = !e;
      2:       t = l;
      3:       t = e || g;
      4:       t = 1'b1;
      default: t = 1'b0;
    endcase
    r.ferr    = is_cond && (nflags != 1);
    r.taken   = t && !r.ferr;
    r.target  = N'((((pc + soff) % MOD) + MOD) % MOD);
    r.next_pc = r.taken ? r.target : N'((pc + INSN) % MOD);
    return r;
  endfunction

  // Monitor: compares held output against the scoreboard head, then retires or drops it.
  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("in_ready", {31'b0, in_ready},
        {31'b0, !rst && !flush && (q.size() == 0 || out_ready)});
    if (rst_last) begin
      chk("rst_taken", {31'b0, taken}, 32'd0);
      chk("rst_ferr", {31'b0, flags_err}, 32'd0);
      chk("rst_target", {16'b0, target}, 32'd0);
      chk("rst_next_pc", {16'b0, next_pc}, 32'd0);
    end else if (q.size() != 0) begin
      chk("taken", {31'b0, taken}, {31'b0, q[0].taken});
      chk("flags_err", {31'b0, flags_err}, {31'b0, q[0].ferr});
      chk("target", {16'b0, target}, {16'b0, q[0].target});
      chk("next_pc", {16'b0, next_pc}, {16'b0, q[0].next_pc});
    end
`ifdef BRANCH_UNIT_STATS_EN
    chk("total_cnt", {16'b0, total_cnt}, m_total);
    chk("taken_cnt", {16'b0, taken_cnt}, m_taken);
`endif
    if (rst || flush)                  q.delete();
    else if (q.size() != 0 && out_ready) void'(q.pop_front());
    rst_last = rst;
  end

  task automatic drive(input bit v, input int op, input bit e, input bit g, input bit l,
                       input int pc, input int off, input bit ordy, input bit fl,
                       input bit r);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; br_op = 3'(op); eq = e; gt = g; lt = l;
    pc_in = N'(pc); offset = N'(off); out_ready = ordy; flush = fl;
    @(negedge clk);
    #1;
    if (r) begin
`ifdef BRANCH_UNIT_STATS_EN
      m_total = 0; m_taken = 0;
`endif
    end else if (v && !fl && q.size() == 0) begin
      x = model(op, e, g, l, pc, off);
      q.push_back(x);
`ifdef BRANCH_UNIT_STATS_EN
      if (m_total < 16'hFFFF) m_total++;
      if (x.taken && m_taken < 16'hFFFF) m_taken++;
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 7, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int op, fl3;
    rst = 1; in_valid = 0; br_op = 0; eq = 0; gt = 0; lt = 0;
    pc_in = 0; offset = 0; out_ready = 1; flush = 0;
    drive(0, 7, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 7, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    // BEQ taken, BLT not taken with negative offset, BGE with bad flags
    drive(1, 0, 1, 0, 0, 16'h0100, 16'h0010, 1, 0, 0);
    drive(1, 2, 0, 1, 0, 16'h0100, 16'hFFF0, 1, 0, 0);
    drive(1, 3, 1, 1, 0, 16'h0200, 16'h0040, 1, 0, 0);
    idle(2);
    // Backpressure: hold FULL for three cycles, then replace without a bubble
    drive(1, 1, 0, 0, 1, 16'h0300, 16'h0020, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 16'h0400, 16'h0008, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 16'h0400, 16'h0008, 1, 0, 0);
    drive(1, 2, 0, 0, 1, 16'h0500, 16'h0006, 1, 0, 0);
    idle(2);
    // JAL wrapping past 2^N, then flush with a competing request
    drive(1, 4, 0, 0, 0, 16'hFFFE, 16'h0004, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 16'h0600, 16'h0002, 0, 1, 0);
    idle(2);
    // Stats scenario: five accepts, three taken, then a one-cycle reset
    drive(1, 0, 1, 0, 0, 16'h0010, 16'h0010, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 16'h0020, 16'h0010, 1, 0, 0);
    drive(1, 4, 0, 0, 0, 16'h0030, 16'h0010, 1, 0, 0);
    drive(1, 2, 0, 0, 1, 16'h0040, 16'h0010, 1, 0, 0);
    drive(1, 7, 1, 0, 0, 16'h0050, 16'h0010, 1, 0, 0);
    idle(1);
    drive(0, 7, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    for (int i = 0; i < 500; i++) begin
      op  = $urandom_range(0, 7);
      fl3 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : (1 << $urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, op, fl3[2], fl3[1], fl3[0],
            $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0);
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter N, default 16: width of the PC, offset, target and next-PC paths.
REQ-002 SHALL have parameter INSN_BYTES, default 2: fall-through PC increment.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: upstream branch request valid.
REQ-006 SHALL have port in_ready  output  1: block can accept the request this cycle.
REQ-007 SHALL have port br_op  input  3: 000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 JAL; all other codes are NOP.
REQ-008 SHALL have ports eq, gt, lt  input  1 each: comparator flags for rs1 versus rs2.
REQ-009 SHALL have port pc_in  input  N: PC of the branch instruction.
REQ-010 SHALL have port offset  input  N: two's-complement branch offset.
REQ-011 SHALL have port flush  input  1: discard the held result.
REQ-012 SHALL have port out_valid  output  1: result register holds a valid result.
REQ-013 SHALL have port out_ready  input  1: downstream accepts the result.
REQ-014 SHALL have port taken  output  1: branch resolved as taken.
REQ-015 SHALL have port target  output  N: pc_in + offset.
REQ-016 SHALL have port next_pc  output  N: target if taken, otherwise pc_in + INSN_BYTES.
REQ-017 SHALL have port flags_err  output  1: {eq,gt,lt} was not one-hot for a conditional op.

Function
REQ-018 SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 SHALL drive in_ready = !flush && (EMPTY || out_ready).
REQ-020 SHALL accept a request on the cycle in_valid && in_ready, and register the result for the next cycle (latency 1); a result accepted while FULL && out_ready replaces the old result with no bubble.
REQ-021 SHALL transition FULL->EMPTY on out_ready with no accept, EMPTY->FULL on accept, and otherwise hold state and outputs stable.
REQ-022 SHALL resolve taken as follows: BEQ=eq; BNE=!eq; BLT=lt; BGE=eq||gt; JAL=1; NOP=0.
REQ-023 SHALL force taken=0 and flags_err=1 for a conditional op (BEQ/BNE/BLT/BGE) whose flags are not exactly one-hot; JAL and NOP ignore the flags and give flags_err=0.
REQ-024 SHALL compute target and pc_in + INSN_BYTES modulo 2^N (wrap-around, no carry out), with offset sign-interpreted.
REQ-025 SHALL make flush force EMPTY on the next cycle and take priority over out_ready and over in_valid; a request presented during flush is not accepted.

Reset
REQ-026 SHALL, on a clock edge with rst=1, set state EMPTY and out_valid, taken, flags_err, target and next_pc to 0, aborting any held result.
REQ-027 SHALL deassert in_ready while rst=1.

Configuration
REQ-028 SHALL, when macro BRANCH_UNIT_STATS_EN is defined, add outputs taken_cnt[15:0] and total_cnt[15:0].
REQ-029 SHALL, with BRANCH_UNIT_STATS_EN, increment total_cnt on every accept and taken_cnt on every accept resolved taken; both saturate at 16'hFFFF and clear on rst.
REQ-030 SHALL, without BRANCH_UNIT_STATS_EN, have neither counter port nor counter logic.

Verification
REQ-031 SHALL cover: BEQ, eq=1, pc_in=16'h0100, offset=16'h0010 -> next cycle out_valid=1, taken=1, target=16'h0110, next_pc=16'h0110.
REQ-032 SHALL cover: BLT, gt=1, pc_in=16'h0100, offset=16'hFFF0 -> taken=0, target=16'h00F0, next_pc=16'h0102.
REQ-033 SHALL cover: BGE with eq=1 and gt=1 -> flags_err=1, taken=0, next_pc=pc_in+2.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles while FULL -> in_ready=0 and outputs stable; then out_ready=1 with in_valid=1 -> new result appears on the next cycle with no bubble.
REQ-035 SHALL cover: JAL, pc_in=16'hFFFE, offset=16'h0004 -> target=16'h0002, taken=1; then flush=1 with in_valid=1 -> out_valid=0 next cycle and the request is not accepted.
REQ-036 SHALL cover, with BRANCH_UNIT_STATS_EN: 5 accepts of which 3 are taken -> total_cnt=5, taken_cnt=3; then rst=1 for one cycle -> both counters 0.
